// File: rtl/led_pwm_driver_if.sv
// Duty-word handshake between control logic and the LED PWM driver.
// The master drives duty_in/duty_valid, and the driver answers with duty_ready.
interface led_pwm_driver_if #(
  parameter int N_CH      = 4,
  parameter int DUTY_BITS = 4
);
  logic [N_CH*DUTY_BITS-1:0] duty_in;
  logic                      duty_valid;
  logic                      duty_ready;

  modport master (
    output duty_in,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_in,
    input  duty_valid,
    output duty_ready
  );
endinterface

// File: rtl/led_pwm_driver.sv
// Multi-channel LED PWM driver. Duty words are double-buffered, and a new word
// only takes effect at a period boundary, so no pulse is ever truncated or merged.
module led_pwm_driver #(
  parameter int N_CH         = 4,
  parameter int DUTY_BITS    = 4,
  parameter int PRESCALE_MAX = 1250
) (
  input  logic                 clk,
  input  logic                 rst,
  led_pwm_driver_if.slave      duty_if,
  input  logic                 enable,
  output logic [N_CH-1:0]      leds,
  output logic                 period_start
);

  localparam int PW = (PRESCALE_MAX > 1) ? $clog2(PRESCALE_MAX) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_MAX - 1);

  typedef logic [N_CH-1:0][DUTY_BITS-1:0] duty_vec_t;

  logic [PW-1:0]        presc_q, presc_d;
  logic [DUTY_BITS-1:0] phase_q, phase_d;
  duty_vec_t            active_q, active_d;
  duty_vec_t            pending_q, pending_d;
  logic                 pending_full_q, pending_full_d;
  logic [N_CH-1:0]      leds_q, leds_d;
  logic                 period_start_q, period_start_d;

  logic tick;
  logic boundary;
  logic xfer;
  logic apply;

  // Ready also drops during reset, so nothing is accepted while the core is held.
  assign duty_if.duty_ready = !pending_full_q && !rst;
  assign xfer               = duty_if.duty_valid && duty_if.duty_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    tick           = (presc_q == PRESC_LAST);
    boundary       = tick && (phase_q == '1);
    apply          = boundary && pending_full_q;

    presc_d        = tick ? '0 : presc_q + 1'b1;
    phase_d        = tick ? phase_q + 1'b1 : phase_q;

    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    active_d       = active_q;

    if (xfer) begin
      pending_d      = duty_if.duty_in;
      pending_full_d = 1'b1;
    end

    // Ready is low whenever apply can fire, so apply and xfer never coincide.
    if (apply) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end

    period_start_d = boundary;

    leds_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      leds_d[i] = enable && (phase_q < active_q[i]);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample their inputs together at the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      phase_q        <= '0;
      active_q       <= '0;
      pending_full_q <= 1'b0;
      leds_q         <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      phase_q        <= phase_d;
      active_q       <= active_d;
      pending_full_q <= pending_full_d;
      leds_q         <= leds_d;
      period_start_q <= period_start_d;
    end
  end

  // NOTE: the shadow word is not reset; its content only matters while pending_full_q marks it valid.
  always_ff @(posedge clk) begin
    pending_q <= pending_d;
  end

  assign leds         = leds_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver: one instance with a two-cycle prescaler
// and a second instance with PRESCALE_MAX=1 for the single-cycle-step corner.
module tb_led_pwm_driver;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       sel_b;
  logic [3:0] leds_a, leds_b;
  logic       ps_a, ps_b;
  logic [3:0] mon_leds;
  logic       mon_ps;

  int checks = 0;
  int errors = 0;

  led_pwm_driver_if #(.N_CH(4), .DUTY_BITS(4)) if_a ();
  led_pwm_driver_if #(.N_CH(4), .DUTY_BITS(4)) if_b ();

  led_pwm_driver #(.N_CH(4), .DUTY_BITS(4), .PRESCALE_MAX(2)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .duty_if      (if_a.slave),
    .enable       (enable),
    .leds         (leds_a),
    .period_start (ps_a)
  );

  led_pwm_driver #(.N_CH(4), .DUTY_BITS(4), .PRESCALE_MAX(1)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .duty_if      (if_b.slave),
    .enable       (1'b1),
    .leds         (leds_b),
    .period_start (ps_b)
  );

  assign mon_leds = sel_b ? leds_b : leds_a;
  assign mon_ps   = sel_b ? ps_b : ps_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Step until the monitored period_start is seen; n = budget+1 when it never arrives.
  task automatic wait_ps(input int budget, output int n, output logic [3:0] acc);
    n   = budget + 1;
    acc = '0;
    for (int k = 1; k <= budget; k++) begin
      cyc();
      #1;
      acc |= mon_leds;
      if (mon_ps) begin
        n = k;
        break;
      end
    end
  endtask

  // Called on a period_start cycle; observes the following full period.
  task automatic measure_period(input string tag, input int period,
                                input int e0, input int e1, input int e2, input int e3);
    int         cnt[4];
    int         first[4];
    int         rises[4];
    int         exp_cnt[4];
    logic [3:0] prev;
    exp_cnt = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      cnt[i]   = 0;
      first[i] = -1;
      rises[i] = 0;
    end
    prev = mon_leds;
    for (int j = 1; j <= period; j++) begin
      cyc();
      if_a.duty_valid = 1'b0;
      if_b.duty_valid = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
        if (mon_leds[i]) begin
          cnt[i]++;
          if (first[i] < 0) first[i] = j;
          if (!prev[i]) rises[i]++;
        end
      end
      prev = mon_leds;
    end
    check($sformatf("%s_ps", tag), mon_ps, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_cnt%0d", tag, i), cnt[i], exp_cnt[i]);
      if (exp_cnt[i] > 0) begin
        check($sformatf("%s_first%0d", tag, i), first[i], 1);
        check($sformatf("%s_runs%0d", tag, i), rises[i], 1);
      end
    end
  endtask

  initial begin
    int         n;
    int         cnt_any;
    int         cnt_all;
    int         ps_cnt;
    int         ps_at;
    logic [3:0] acc;

    rst             = 1'b1;
    enable          = 1'b1;
    sel_b           = 1'b0;
    if_a.duty_valid = 1'b1;
    if_a.duty_in    = 16'hF840;
    if_b.duty_valid = 1'b0;
    if_b.duty_in    = 16'h0000;

    // Reset held with a word already offered.
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      check("rst_leds", leds_a, 0);
      check("rst_ps", ps_a, 0);
      check("rst_ready", if_a.duty_ready, 0);
    end
    cyc();
    rst = 1'b0;
    #1;
    check("ready_after_rst", if_a.duty_ready, 1);
    cyc();
    if_a.duty_valid = 1'b0;
    #1;
    check("ready_after_xfer", if_a.duty_ready, 0);

    // Word {15,8,4,0} waits for the first boundary.
    wait_ps(40, n, acc);
    check("first_ps_latency", n, 31);
    check("leds_before_boundary", acc, 0);
    measure_period("load", 32, 0, 8, 16, 30);
    measure_period("load2", 32, 0, 8, 16, 30);

    // Back-pressure: A accepted, B held until A is applied.
    if_a.duty_in    = 16'h1234;
    if_a.duty_valid = 1'b1;
    #1;
    check("bp_ready_a", if_a.duty_ready, 1);
    n = 41;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if_a.duty_in = 16'h5555;
      #1;
      if (if_a.duty_ready) begin
        n = k;
        break;
      end
    end
    check("bp_ready_rise", n, 32);
    check("bp_rise_at_ps", ps_a, 1);
    measure_period("word_a", 32, 8, 6, 4, 2);
    measure_period("word_b", 32, 10, 10, 10, 10);

    // Transfer on the boundary cycle itself.
    for (int k = 0; k < 31; k++) cyc();
    if_a.duty_in    = 16'h2222;
    if_a.duty_valid = 1'b1;
    #1;
    check("coinc_ready", if_a.duty_ready, 1);
    check("coinc_not_ps", ps_a, 0);
    cyc();
    if_a.duty_valid = 1'b0;
    #1;
    check("coinc_ps", ps_a, 1);
    check("coinc_pending", if_a.duty_ready, 0);
    measure_period("coinc_old", 32, 10, 10, 10, 10);
    measure_period("coinc_new", 32, 4, 4, 4, 4);

    // Enable gating with duty 8 on every channel.
    if_a.duty_in    = 16'h8888;
    if_a.duty_valid = 1'b1;
    measure_period("pre_en", 32, 4, 4, 4, 4);
    measure_period("en_on", 32, 16, 16, 16, 16);
    for (int k = 0; k < 5; k++) cyc();
    enable = 1'b0;
    #1;
    check("en_last_on", leds_a, 4'hF);
    acc    = '0;
    ps_cnt = 0;
    ps_at  = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      #1;
      acc |= leds_a;
      if (ps_a) begin
        ps_cnt++;
        ps_at = k;
      end
    end
    check("en_off_leds", acc, 0);
    check("en_off_ps_cnt", ps_cnt, 1);
    check("en_off_ps_pos", ps_at, 27);
    enable  = 1'b1;
    n       = 41;
    cnt_any = 0;
    cnt_all = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      #1;
      if (leds_a != 4'h0) cnt_any++;
      if (leds_a == 4'hF) cnt_all++;
      if (ps_a) begin
        n = k;
        break;
      end
    end
    check("en_resume_ps", n, 19);
    check("en_resume_any", cnt_any, 3);
    check("en_resume_all", cnt_all, 3);
    measure_period("en_resume", 32, 16, 16, 16, 16);

    // Reset mid-period with a pending word, at phase 10.
    if_a.duty_in    = 16'hFFFF;
    if_a.duty_valid = 1'b1;
    cyc();
    if_a.duty_valid = 1'b0;
    #1;
    check("mid_pending_full", if_a.duty_ready, 0);
    for (int k = 0; k < 19; k++) cyc();
    rst = 1'b1;
    #1;
    check("mid_rst_ready", if_a.duty_ready, 0);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check("rst_pending_dropped", if_a.duty_ready, 1);
    wait_ps(40, n, acc);
    check("rst_first_ps", n, 32);
    check("rst_leds_off", acc, 0);
    measure_period("after_rst", 32, 0, 0, 0, 0);

    // Single-cycle phase steps: 16-cycle period, duty 3.
    sel_b = 1'b1;
    #1;
    check("b_ps_aligned", ps_b, 1);
    check("b_ready", if_b.duty_ready, 1);
    if_b.duty_in    = 16'h3333;
    if_b.duty_valid = 1'b1;
    measure_period("b_old", 16, 0, 0, 0, 0);
    measure_period("b_duty3", 16, 3, 3, 3, 3);
    measure_period("b_duty3_2", 16, 3, 3, 3, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
